// File: rtl/hilo_div_sequencer.sv
// Iterative restoring divider that feeds the HI/LO registers and stalls the pipeline while iterating.
// Optional build macro HILO_DIV_EARLY_EXIT_EN: finish in one cycle when |divisor| > |dividend|.
module hilo_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             stall_req_o,
  output logic             busy_o,
  output logic             hilo_write_en_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             quoNeg_q, quoNeg_d;
  logic             remNeg_q, remNeg_d;

  logic             dvdSign, dvsSign;
  logic [WIDTH-1:0] dvdAbs, dvsAbs;
  logic [WIDTH:0]   remShift, remDiff;
  logic             stepGe;
  logic [WIDTH-1:0] remStep, quoStep;

  assign dvdSign = is_signed_i & dividend_i[WIDTH-1];
  assign dvsSign = is_signed_i & divisor_i[WIDTH-1];
  assign dvdAbs  = dvdSign ? -dividend_i : dividend_i;
  assign dvsAbs  = dvsSign ? -divisor_i : divisor_i;

  // quo_q starts out holding the dividend magnitude; its MSB feeds the remainder on each shift.
  assign remShift = {rem_q, quo_q[WIDTH-1]};
  assign remDiff  = remShift - {1'b0, dvs_q};
  assign stepGe   = ~remDiff[WIDTH];
  assign remStep  = stepGe ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
  assign quoStep  = {quo_q[WIDTH-2:0], stepGe};

  assign busy_o = (state_q != IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    dvs_d           = dvs_q;
    hi_d            = hi_q;
    lo_d            = lo_q;
    quoNeg_d        = quoNeg_q;
    remNeg_d        = remNeg_q;
    stall_req_o     = 1'b0;
    hilo_write_en_o = 1'b0;

    if (flush_i) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            stall_req_o = 1'b1;
            rem_d       = '0;
            quo_d       = dvdAbs;
            dvs_d       = dvsAbs;
            quoNeg_d    = dvdSign ^ dvsSign;
            remNeg_d    = dvdSign;
            count_d     = '0;
            // Shortcut results are loaded raw, bypassing sign correction.
            if (divisor_i == '0) begin
              state_d = DONE;
              lo_d    = '1;
              hi_d    = dividend_i;
            end
`ifdef HILO_DIV_EARLY_EXIT_EN
            else if (dvsAbs > dvdAbs) begin
              state_d = DONE;
              lo_d    = '0;
              hi_d    = dividend_i;
            end
`endif
            else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          stall_req_o = 1'b1;
          rem_d       = remStep;
          quo_d       = quoStep;
          count_d     = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            count_d = '0;
            hi_d    = remNeg_q ? -remStep : remStep;
            lo_d    = quoNeg_q ? -quoStep : quoStep;
          end
        end
        DONE: begin
          hilo_write_en_o = 1'b1;
          state_d         = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      quoNeg_q <= 1'b0;
      remNeg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      quoNeg_q <= quoNeg_d;
      remNeg_q <= remNeg_d;
    end
  end

endmodule
